// File: rtl/herm_pkg.sv
// Shared defaults, keep-mode encoding and a constant-safe clog2 for the
// Hermitian-symmetry remover and its ping-pong buffer.
package herm_pkg;

  localparam int FFT_POINT      = 64;
  localparam int ACTIVE_SUBCARR = 28;
  localparam int SYMBOL_NUM     = 8;
  localparam int CEST_NUM       = 4;
  localparam int DATA_W         = 16;

  typedef enum logic {
    KEEP_LOW    = 1'b0,
    KEEP_MIRROR = 1'b1
  } keep_mode_e;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int unsigned x = 1; x < v; x = x << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/herm_extract_pp_if.sv
// Sample-in / buffer-read bundle of herm_extract_pp; master drives stimulus
// and read requests, slave is the extractor.
interface herm_extract_pp_if import herm_pkg::*; #(
  parameter int DATA_W = herm_pkg::DATA_W,
  parameter int AW     = herm_pkg::clog2(herm_pkg::ACTIVE_SUBCARR *
                                         (herm_pkg::SYMBOL_NUM + herm_pkg::CEST_NUM))
);
  logic [DATA_W-1:0] din;
  logic              wren;
  logic              mode;
  logic [AW-1:0]     read_ptr;
  logic              rd_en;
  logic              rd_release;
  logic [DATA_W-1:0] dout;
  logic              out_buff_full;
  logic              overflow;

  modport master (
    output din, wren, mode, read_ptr, rd_en, rd_release,
    input  dout, out_buff_full, overflow
  );

  modport slave (
    input  din, wren, mode, read_ptr, rd_en, rd_release,
    output dout, out_buff_full, overflow
  );
endinterface

// File: rtl/herm_pp_bram.sv
// Simple dual-port RAM: one write port, one registered read port whose
// output register resets to zero (array contents are not reset).
module herm_pp_bram #(
  parameter int DATA_W  = 16,
  parameter int ENTRIES = 672,
  parameter int RAW     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [RAW-1:0]    waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [RAW-1:0]    raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [ENTRIES];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/herm_extract_pp.sv
// Drops conjugate/unused FFT bins and packs a burst's active subcarriers into
// one bank of a ping-pong buffer read by pointer.
module herm_extract_pp import herm_pkg::*; #(
  parameter int FFT_POINT      = herm_pkg::FFT_POINT,
  parameter int ACTIVE_SUBCARR = herm_pkg::ACTIVE_SUBCARR,
  parameter int SYMBOL_NUM     = herm_pkg::SYMBOL_NUM,
  parameter int CEST_NUM       = herm_pkg::CEST_NUM,
  parameter int DATA_W         = herm_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_done,
  herm_extract_pp_if.slave  bus
);
  localparam int N         = FFT_POINT;
  localparam int A         = ACTIVE_SUBCARR;
  localparam int SYM_TOTAL = SYMBOL_NUM + CEST_NUM;
  localparam int DEPTH     = A * SYM_TOTAL;
  localparam int RAW       = clog2(2 * DEPTH);
  localparam int BW        = clog2(N);
  localparam int SW        = (SYM_TOTAL > 1) ? clog2(SYM_TOTAL) : 1;

  logic [BW-1:0] bin_q, bin_d;
  logic [SW-1:0] sym_q, sym_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [1:0]    full_q, full_d;
  logic          ovf_q, ovf_d;
  keep_mode_e    mode_q, mode_d;
  logic          discard_q, discard_d;

  logic          first_smp, burst_end, keep, we, re;
  keep_mode_e    mode_cur;
  logic          disc_cur;
  logic [31:0]   slot;
  logic [RAW-1:0] waddr, raddr;

  always_comb begin
    first_smp = (bin_q == '0) && (sym_q == '0);
    // mode and discard decision are taken live on a burst's first sample,
    // then held in registers for the rest of the burst
    mode_cur  = first_smp ? keep_mode_e'(bus.mode) : mode_q;
    disc_cur  = first_smp ? full_q[wb_q] : discard_q;
    burst_end = bus.wren && (32'(bin_q) == 32'(N - 1)) &&
                (32'(sym_q) == 32'(SYM_TOTAL - 1));

    keep = 1'b0;
    slot = '0;
    if (mode_cur == KEEP_LOW) begin
      keep = (32'(bin_q) >= 32'd1) && (32'(bin_q) <= 32'(A));
      slot = 32'(bin_q) - 32'd1;
    end else begin
      keep = 32'(bin_q) >= 32'(N - A);
      slot = 32'(N - 1) - 32'(bin_q);
    end

    we    = bus.wren && keep && !disc_cur && !tx_done;
    waddr = RAW'(32'(wb_q) * 32'(DEPTH) + 32'(sym_q) * 32'(A) + slot);
    re    = bus.rd_en && (32'(bus.read_ptr) < 32'(DEPTH));
    raddr = RAW'(32'(rb_q) * 32'(DEPTH) + 32'(bus.read_ptr));
  end

  always_comb begin
    bin_d     = bin_q;
    sym_d     = sym_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
    full_d    = full_q;
    ovf_d     = ovf_q;
    mode_d    = mode_q;
    discard_d = discard_q;

    // release clears rb's flag; burst end sets wb's flag. When wb==rb the
    // release is necessarily ignored (bank was empty), so order is free.
    if (bus.rd_release && full_q[rb_q]) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end

    if (bus.wren) begin
      if (first_smp) begin
        mode_d    = mode_cur;
        discard_d = disc_cur;
        if (disc_cur) ovf_d = 1'b1;
      end
      if (burst_end) begin
        bin_d = '0;
        sym_d = '0;
        if (!disc_cur) begin
          full_d[wb_q] = 1'b1;
          wb_d         = ~wb_q;
        end
      end else if (32'(bin_q) == 32'(N - 1)) begin
        bin_d = '0;
        sym_d = sym_q + SW'(1);
      end else begin
        bin_d = bin_q + BW'(1);
      end
    end

    if (tx_done) begin
      bin_d     = '0;
      sym_d     = '0;
      wb_d      = 1'b0;
      rb_d      = 1'b0;
      full_d    = '0;
      ovf_d     = 1'b0;
      mode_d    = KEEP_LOW;
      discard_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      sym_q     <= '0;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      full_q    <= '0;
      ovf_q     <= 1'b0;
      mode_q    <= KEEP_LOW;
      discard_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      sym_q     <= sym_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      mode_q    <= mode_d;
      discard_q <= discard_d;
    end
  end

  herm_pp_bram #(
    .DATA_W (DATA_W),
    .ENTRIES(2 * DEPTH),
    .RAW    (RAW)
  ) u_bram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(bus.din),
    .re_i   (re),
    .raddr_i(raddr),
    .rdata_o(bus.dout)
  );

  assign bus.out_buff_full = full_q[rb_q];
  assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_herm_extract_pp.sv
// Scoreboard bench for herm_extract_pp: bursts are modelled as whole
// subcarrier images held in a two-deep ready queue.
module tb_herm_extract_pp;
  import herm_pkg::*;

  localparam int N     = herm_pkg::FFT_POINT;
  localparam int A     = herm_pkg::ACTIVE_SUBCARR;
  localparam int ST    = herm_pkg::SYMBOL_NUM + herm_pkg::CEST_NUM;
  localparam int DEPTH = A * ST;
  localparam int DW    = herm_pkg::DATA_W;
  localparam int AW    = herm_pkg::clog2(DEPTH);

  typedef logic [DW-1:0] bank_t [DEPTH];
  typedef struct {
    bit          care;
    logic [DW-1:0] exp;
    int          ptr;
  } rd_exp_t;

  logic clk, rst_n, tx_done;
  herm_extract_pp_if #(.DATA_W(DW), .AW(AW)) bus ();

  herm_extract_pp #(
    .FFT_POINT     (N),
    .ACTIVE_SUBCARR(A),
    .SYMBOL_NUM    (herm_pkg::SYMBOL_NUM),
    .CEST_NUM      (herm_pkg::CEST_NUM),
    .DATA_W        (DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx_done(tx_done),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bank_t   ready_q[$];
  bit      ovf_m;
  rd_exp_t sb_q[$];
  int      vectors, miscompares;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drives one read request for the coming edge and records its expectation
  task automatic issue_read(input int ptr, input bit fixed, input logic [DW-1:0] val);
    rd_exp_t e;
    e.ptr  = ptr;
    e.care = (ptr < DEPTH) && (fixed || ready_q.size() > 0);
    e.exp  = fixed ? val : ((e.care) ? ready_q[0][ptr] : '0);
    sb_q.push_back(e);
    bus.read_ptr = AW'(ptr);
    bus.rd_en    = 1'b1;
  endtask

  task automatic do_read(input int ptr, input bit fixed, input logic [DW-1:0] val);
    issue_read(ptr, fixed, val);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic chk_flags(input string tag);
    @(negedge clk);
    check({tag, "_full"}, 32'(bus.out_buff_full), 32'(ready_q.size() > 0));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf_m));
  endtask

  task automatic release_bank();
    bus.rd_release = 1'b1;
    tick();
    bus.rd_release = 1'b0;
    if (ready_q.size() > 0) void'(ready_q.pop_front());
    chk_flags("release");
  endtask

  task automatic run_burst(input bit m, input bit rand_data, input int start,
                           input int gap_pct, input int rd_pct, input bit rel_end,
                           input int abort_at, input bit chk_edge);
    logic [DW-1:0] smp [ST*N];
    bank_t img;
    bit    disc;
    disc = (ready_q.size() == 2);
    for (int idx = 0; idx < ST * N; idx++) begin
      if (abort_at >= 0 && idx == abort_at) begin
        bus.wren  = 1'b0;
        bus.rd_en = 1'b0;
        return;
      end
      if ($urandom_range(99) < gap_pct) begin
        repeat ($urandom_range(1, 5)) begin
          bus.wren = 1'b0;
          bus.mode = 1'($urandom);
          if ($urandom_range(99) < rd_pct && ready_q.size() > 0)
            issue_read($urandom_range(DEPTH - 1), 1'b0, '0);
          else
            bus.rd_en = 1'b0;
          tick();
        end
      end
      smp[idx] = rand_data ? DW'($urandom) : DW'(start + idx);
      bus.din  = smp[idx];
      bus.wren = 1'b1;
      bus.mode = (idx == 0) ? m : 1'($urandom);
      if ($urandom_range(99) < rd_pct && ready_q.size() > 0)
        issue_read($urandom_range(DEPTH - 1), 1'b0, '0);
      else
        bus.rd_en = 1'b0;
      bus.rd_release = (idx == ST * N - 1) && rel_end;
      if (idx == ST * N - 1 && chk_edge) begin
        @(negedge clk);
        check("full_before_last_edge", 32'(bus.out_buff_full), 32'(ready_q.size() > 0));
      end
      tick();
    end
    bus.wren       = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_release = 1'b0;
    if (rel_end && ready_q.size() > 0) void'(ready_q.pop_front());
    if (disc) begin
      ovf_m = 1'b1;
    end else begin
      // subcarrier k of symbol s is bin k (low) or its mirror bin N-k
      for (int s = 0; s < ST; s++)
        for (int k = 1; k <= A; k++)
          img[s*A + k - 1] = m ? smp[s*N + N - k] : smp[s*N + k];
      ready_q.push_back(img);
    end
    chk_flags("burst_end");
  endtask

  // scoreboard monitor: one registered response per accepted read strobe
  initial begin
    rd_exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && bus.rd_en) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_read: got 0x%0h, expected no read", bus.dout);
        end else begin
          e = sb_q.pop_front();
          if (e.care) check($sformatf("dout_slot%0d", e.ptr), 32'(bus.dout), 32'(e.exp));
        end
      end
    end
  end

  initial begin
    vectors = 0; miscompares = 0; ovf_m = 1'b0;
    rst_n = 1'b0; tx_done = 1'b0;
    bus.din = '0; bus.wren = 1'b0; bus.mode = 1'b0;
    bus.read_ptr = '0; bus.rd_en = 1'b0; bus.rd_release = 1'b0;
    repeat (3) tick();
    check("reset_dout", 32'(bus.dout), 32'd0);
    check("reset_full", 32'(bus.out_buff_full), 32'd0);
    check("reset_ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // mode 0 and mode 1 directed bursts
    run_burst(1'b0, 1'b0, 0, 0, 0, 1'b0, -1, 1'b1);
    do_read(0, 1'b1, 16'd1);
    do_read(27, 1'b1, 16'd28);
    do_read(28, 1'b1, 16'd65);
    do_read(335, 1'b1, 16'd732);
    release_bank();
    run_burst(1'b1, 1'b0, 0, 0, 0, 1'b0, -1, 1'b0);
    do_read(0, 1'b1, 16'd63);
    do_read(27, 1'b1, 16'd36);
    do_read(28, 1'b1, 16'd127);
    release_bank();

    // ping-pong fill then a discarded third burst
    run_burst(1'b0, 1'b0, 0, 0, 0, 1'b0, -1, 1'b0);
    run_burst(1'b0, 1'b0, 768, 0, 0, 1'b0, -1, 1'b0);
    run_burst(1'b0, 1'b0, 1536, 0, 0, 1'b0, -1, 1'b0);
    do_read(0, 1'b1, 16'd1);
    release_bank();
    do_read(0, 1'b1, 16'd769);
    release_bank();

    // release coincident with second burst end
    run_burst(1'b0, 1'b0, 0, 0, 0, 1'b0, -1, 1'b0);
    run_burst(1'b0, 1'b0, 768, 0, 0, 1'b1, -1, 1'b0);
    do_read(0, 1'b1, 16'd769);
    do_read(100, 1'b0, '0);

    // tx_done mid-burst while a bank is ready and overflow is sticky
    run_burst(1'b0, 1'b0, 100, 0, 0, 1'b0, 300, 1'b0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    ready_q.delete();
    ovf_m = 1'b0;
    chk_flags("tx_done");
    run_burst(1'b0, 1'b0, 0, 0, 0, 1'b0, -1, 1'b0);
    do_read(0, 1'b1, 16'd1);
    do_read(5, 1'b0, '0);

    // asynchronous reset mid-burst
    run_burst(1'b1, 1'b1, 0, 0, 0, 1'b0, int'($urandom_range(100, 700)), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(bus.dout), 32'd0);
    check("async_rst_full", 32'(bus.out_buff_full), 32'd0);
    check("async_rst_ovf", 32'(bus.overflow), 32'd0);
    ready_q.delete();
    ovf_m = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_burst(1'($urandom), 1'b1, 0, 30, 0, 1'b0, -1, 1'b0);
    do_read(0, 1'b0, '0);
    do_read(DEPTH - 1, 1'b0, '0);
    for (int i = 0; i < 10; i++) do_read($urandom_range(DEPTH - 1), 1'b0, '0);

    // randomized bursts, releases, out-of-range reads
    for (int it = 0; it < 8; it++) begin
      run_burst(1'($urandom), 1'b1, 0, 15, 10, 1'($urandom), -1, 1'b0);
      if ($urandom_range(3) == 0) begin
        do_read(DEPTH + $urandom_range(511 - DEPTH), 1'b0, '0);
        chk_flags("bad_ptr");
      end
      for (int i = 0; i < 3; i++)
        if (ready_q.size() > 0) do_read($urandom_range(DEPTH - 1), 1'b0, '0);
      if ($urandom_range(1) == 0) release_bank();
    end
    while (ready_q.size() > 0) begin
      do_read($urandom_range(DEPTH - 1), 1'b0, '0);
      release_bank();
    end

    for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/herm_extract_pp.md
# herm_extract_pp

Parametrised Hermitian-symmetry remover for the VLC OFDM receive path. It sits after the FFT and drops the redundant conjugate half and the unused bins of each FFT symbol on the fly. The active subcarriers of a whole burst (channel-estimation plus data symbols) are packed into one bank of a ping-pong output buffer. Downstream logic reads a completed bank by pointer while the next burst fills the other bank.

## Interface
- `FFT_POINT`, 64: FFT size N; power of two, ≥ 8.
- `ACTIVE_SUBCARR`, 28: active bins per symbol A; 1 ≤ A ≤ N/2−1.
- `SYMBOL_NUM`, 8: data symbols per burst.
- `CEST_NUM`, 4: channel-estimation symbols per burst.
- `DATA_W`, 16: sample width.
- Derived: `SYM_TOTAL = SYMBOL_NUM+CEST_NUM`, `DEPTH = A*SYM_TOTAL` (default 336), `AW = clog2(DEPTH)`.
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `tx_done`, in, 1: synchronous burst abort/clear.
- `din`, in, `DATA_W`: FFT output sample, natural bin order 0..N−1, symbol after symbol.
- `wren`, in, 1: `din` valid this cycle. No backpressure.
- `mode`, in, 1: 0 = keep bins 1..A; 1 = keep mirror bins N−1 down to N−A.
- `read_ptr`, in, `AW`: read address within the ready bank.
- `rd_en`, in, 1: read strobe.
- `rd_release`, in, 1: one-cycle pulse; the ready bank has been consumed.
- `dout`, out, `DATA_W`: read data.
- `out_buff_full`, out, 1: at least one bank is full and readable.
- `overflow`, out, 1: sticky; a burst was dropped.

## Operation
- Write side uses a bin counter `bin` (0..N−1), a symbol counter `sym` (0..SYM_TOTAL−1) and a write-bank pointer `wb`. Both counters advance only on `wren`; `bin` wraps to 0 and increments `sym`.
- `mode` is sampled on the first sample of a burst (`bin==0`, `sym==0`) and held until that burst ends.
- Keep rule, mode 0: keep if 1 ≤ bin ≤ A; `slot = bin−1`.
- Keep rule, mode 1: keep if N−A ≤ bin ≤ N−1; `slot = N−1−bin`. Bin N−k lands at slot k−1, so both modes deliver the same subcarrier order.
- Write address = `sym*A + slot` in bank `wb`. Dropped bins are never written.
- Burst end is the accepted sample with `bin==N−1` and `sym==SYM_TOTAL−1`. On that cycle:
  - `full[wb]` is set (unless the burst is being discarded);
  - `wb` toggles;
  - both counters return to 0.
- Discard: if `full[wb]` is already set on a burst's first sample, the whole burst is discarded. No writes occur, counting continues to the burst boundary, `overflow` is set, and `full` and `wb` are unchanged at the burst end.
- Read side uses a read-bank pointer `rb`. `out_buff_full = full[rb]`.
  - `rd_en` reads `{rb, read_ptr}`.
  - `read_ptr ≥ DEPTH` returns an undefined value and has no side effects.
  - `rd_release` with `full[rb]` set clears `full[rb]` and toggles `rb`. `rd_release` with `full[rb]` clear is ignored.
  - `rd_en` while `out_buff_full==0` is permitted; it returns stale data.
- Simultaneous events:
  - Burst end and `rd_release` in the same cycle: both take effect. Set and clear target different banks; if `wb==rb`, the set happens because the bank was empty.
  - `tx_done` wins over everything. It clears counters, `wb`, `rb`, `full[1:0]` and `overflow`, and discards a partial burst.
- Reset values: `dout=0`, `out_buff_full=0`, `overflow=0`, all counters and pointers 0. RAM contents are not reset.

## Timing
- Write path: the kept sample is in RAM one cycle after the `wren` cycle. `full` is set on the edge that accepts the last sample, so `out_buff_full` rises on the following cycle. Latency from last `din` to readable is 1 cycle.
- Read path: `dout` is registered and valid 1 cycle after `rd_en`. It holds its value while `rd_en` is low.
- Throughput: one input sample per cycle sustained, with `wren` continuous across symbols and bursts. Gaps in `wren` are allowed anywhere.
- `rst_n` is asserted asynchronously and deasserted synchronously; the deassertion synchroniser lives outside this block.

## Structure
- Package `herm_pkg`: default constants (FFT_POINT, ACTIVE_SUBCARR, SYMBOL_NUM, CEST_NUM, DATA_W) and a `clog2` function.
- Sub-module `herm_pp_bram`: simple dual-port RAM, 2·DEPTH × DATA_W, with one write port and one registered read port. The top block holds the counters, keep/slot logic, bank flags and read control.

## Test plan
- Mode 0 defaults: one burst, `din = sym*64+bin`, continuous `wren`. Expect `out_buff_full` high 1 cycle after sample 767; slot 0 = 1, slot 27 = 28, slot 28 = 65, slot 335 = 732.
- Mode 1: same stimulus. Expect slot 0 = 63, slot 27 = 36, slot 28 = 127.
- Ping-pong: two back-to-back bursts with no release, then a third burst. Both banks end full; burst 3 is discarded and `overflow=1`. Releasing once exposes burst 2 data (slot 0 = 769).
- Release coincident with burst-2 end: no data lost, `out_buff_full` stays 1, and the next read returns burst-2 data.
- `tx_done` mid-burst at sample 300, then a fresh burst. Expect flags cleared and the new burst to land in bank 0 with correct slot 0.
- `rst_n` pulsed low mid-burst. Expect all outputs 0 immediately, then correct operation on the next full burst. Also check `wren` gaps of random length, which must give identical stored data.
